// File: rtl/dphy_hs_lane_ctrl.sv
// dphy_hs_lane_ctrl
// Per-lane D-PHY data-lane sequencer. It takes bursts from the FIFO-to-lane
// bridge and runs the lane through LP-11 -> LP-01 -> LP-00 -> HS-zero ->
// sync -> payload -> trail -> LP-11, one HS byte per clock.
//
// Ports:
//   clk          lane byte clock
//   rst          synchronous active-high reset
//   mode_lp      burst mode from bridge (0 = HS, 1 = LP request, drained)
//   start_rqst   one-cycle burst start pulse, inp_data holds the first byte
//   fin_rqst     current inp_data is the final byte of the burst
//   inp_data     payload byte from bridge
//   data_rqst    byte consumed this cycle (combinational)
//   hs_data      byte to serializer, LSB first
//   hs_en        HS driver / serializer enable
//   lp_dp/lp_dn  LP line levels
//   busy         sequencer not idle
//   err_lp_rqst  one-cycle pulse when an LP-mode start is rejected
//   burst_cnt    completed HS bursts (only with DSI_LANE_BURST_CNT_EN)
//
// Optional feature macro: DSI_LANE_BURST_CNT_EN adds the burst_cnt output.
//
// The registered line outputs describe the state held during the previous
// clock, so hs_data carries a payload byte in the cycle after data_rqst
// consumed it, and all line outputs stay mutually aligned.
module dphy_hs_lane_ctrl #(
  parameter logic [7:0] T_LPX        = 8'd4,
  parameter logic [7:0] T_HS_PREPARE = 8'd3,
  parameter logic [7:0] T_HS_ZERO    = 8'd10,
  parameter logic [7:0] T_HS_TRAIL   = 8'd4,
  parameter logic [7:0] T_HS_EXIT    = 8'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_lp,
  input  logic       start_rqst,
  input  logic       fin_rqst,
  input  logic [7:0] inp_data,
  output logic       data_rqst,
  output logic [7:0] hs_data,
  output logic       hs_en,
  output logic       lp_dp,
  output logic       lp_dn,
  output logic       busy,
  output logic       err_lp_rqst
`ifdef DSI_LANE_BURST_CNT_EN
  ,
  output logic [15:0] burst_cnt
`endif
);

  typedef enum logic [3:0] {
    S_IDLE, S_LPX, S_PREP, S_ZERO, S_SYNC, S_DATA, S_TRAIL, S_EXIT, S_DRAIN
  } state_t;

  // Timer load value: a zero-length parameter still occupies one cycle.
  function automatic logic [7:0] load_val(input logic [7:0] p);
    load_val = (p == 8'd0) ? 8'd0 : (p - 8'd1);
  endfunction

  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       pending_q, pending_d;
  logic       pend_mode_q, pend_mode_d;
  logic       last_bit_q, last_bit_d;
  logic [7:0] hs_data_q, hs_data_d;
  logic       hs_en_q, hs_en_d;
  logic       lp_dp_q, lp_dp_d;
  logic       lp_dn_q, lp_dn_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;
`ifdef DSI_LANE_BURST_CNT_EN
  logic [15:0] burst_cnt_q, burst_cnt_d;
`endif

  // Next-state, timer, pending-start and burst bookkeeping.
  always_comb begin
    state_d     = state_q;
    timer_d     = (timer_q != 8'd0) ? (timer_q - 8'd1) : 8'd0;
    pending_d   = pending_q;
    pend_mode_d = pend_mode_q;
    last_bit_d  = last_bit_q;
    err_d       = 1'b0;
`ifdef DSI_LANE_BURST_CNT_EN
    burst_cnt_d = burst_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_rqst && mode_lp) begin
          state_d = S_DRAIN;
          err_d   = 1'b1;
        end else if (start_rqst) begin
          state_d = S_LPX;
          timer_d = load_val(T_LPX);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LPX: begin
        if (timer_q == 8'd0) begin
          state_d = S_PREP;
          timer_d = load_val(T_HS_PREPARE);
        end else begin
          state_d = S_LPX;
        end
      end
      S_PREP: begin
        if (timer_q == 8'd0) begin
          state_d = S_ZERO;
          timer_d = load_val(T_HS_ZERO);
        end else begin
          state_d = S_PREP;
        end
      end
      S_ZERO: begin
        if (timer_q == 8'd0) begin
          state_d = S_SYNC;
        end else begin
          state_d = S_ZERO;
        end
      end
      S_SYNC: begin
        state_d = S_DATA;
      end
      S_DATA: begin
        last_bit_d = inp_data[7];
        if (fin_rqst) begin
          state_d = S_TRAIL;
          timer_d = load_val(T_HS_TRAIL);
        end else begin
          state_d = S_DATA;
        end
      end
      S_TRAIL: begin
        if (timer_q == 8'd0) begin
          state_d = S_EXIT;
          timer_d = load_val(T_HS_EXIT);
`ifdef DSI_LANE_BURST_CNT_EN
          burst_cnt_d = burst_cnt_q + 16'd1;
`endif
        end else begin
          state_d = S_TRAIL;
        end
      end
      S_EXIT: begin
        // A start arriving here is remembered and replayed when EXIT ends,
        // including one arriving on the very last EXIT cycle.
        if (start_rqst) begin
          pending_d   = 1'b1;
          pend_mode_d = mode_lp;
        end else begin
          pending_d   = pending_q;
        end
        if (timer_q == 8'd0) begin
          pending_d = 1'b0;
          if ((pending_q || start_rqst) && pend_mode_d) begin
            state_d = S_DRAIN;
            err_d   = 1'b1;
          end else if (pending_q || start_rqst) begin
            state_d = S_LPX;
            timer_d = load_val(T_LPX);
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_EXIT;
        end
      end
      S_DRAIN: begin
        if (fin_rqst) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Line outputs decoded from the current state, registered below.
  always_comb begin
    hs_en_d   = 1'b0;
    lp_dp_d   = 1'b1;
    lp_dn_d   = 1'b1;
    hs_data_d = 8'h00;
    busy_d    = (state_q != S_IDLE);
    case (state_q)
      S_LPX: begin
        lp_dp_d = 1'b0;
      end
      S_PREP, S_ZERO: begin
        hs_en_d = 1'b1;
        lp_dp_d = 1'b0;
        lp_dn_d = 1'b0;
      end
      S_SYNC: begin
        hs_en_d   = 1'b1;
        lp_dp_d   = 1'b0;
        lp_dn_d   = 1'b0;
        hs_data_d = 8'hB8;
      end
      S_DATA: begin
        hs_en_d   = 1'b1;
        lp_dp_d   = 1'b0;
        lp_dn_d   = 1'b0;
        hs_data_d = inp_data;
      end
      S_TRAIL: begin
        // Trail holds the inverse of the final payload bit.
        hs_en_d   = 1'b1;
        lp_dp_d   = 1'b0;
        lp_dn_d   = 1'b0;
        hs_data_d = {8{~last_bit_q}};
      end
      default: begin
        hs_en_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= 8'd0;
      pending_q   <= 1'b0;
      pend_mode_q <= 1'b0;
      last_bit_q  <= 1'b0;
      hs_data_q   <= 8'h00;
      hs_en_q     <= 1'b0;
      lp_dp_q     <= 1'b1;
      lp_dn_q     <= 1'b1;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef DSI_LANE_BURST_CNT_EN
      burst_cnt_q <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      pending_q   <= pending_d;
      pend_mode_q <= pend_mode_d;
      last_bit_q  <= last_bit_d;
      hs_data_q   <= hs_data_d;
      hs_en_q     <= hs_en_d;
      lp_dp_q     <= lp_dp_d;
      lp_dn_q     <= lp_dn_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
`ifdef DSI_LANE_BURST_CNT_EN
      burst_cnt_q <= burst_cnt_d;
`endif
    end
  end

  assign data_rqst   = (state_q == S_DATA) || (state_q == S_DRAIN);
  assign hs_data     = hs_data_q;
  assign hs_en       = hs_en_q;
  assign lp_dp       = lp_dp_q;
  assign lp_dn       = lp_dn_q;
  assign busy        = busy_q;
  assign err_lp_rqst = err_q;
`ifdef DSI_LANE_BURST_CNT_EN
  assign burst_cnt   = burst_cnt_q;
`endif

endmodule
